// File: rtl/fir_stream_pkg.sv
// Shared types and constants for the FIR stream source: mode encoding,
// sample type and the fixed generator amplitudes.
package fir_stream_pkg;

    localparam int SAMPLE_W = 6;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        MODE_PIN     = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_IMPULSE = 2'd2,
        MODE_STEP    = 2'd3
    } mode_e;

    // Largest positive value of a signed sample; used by both impulse and step.
    localparam sample_t IMPULSE_VAL = 6'h1F;

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and a sticky overflow flag.
// Pointers carry one extra bit so full and empty are told apart by the MSB.
module fir_sync_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     rd_ready,
    input  logic                     clear_ovf,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     push_accepted,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop           = !empty && rd_ready;
    assign push_accepted = push && (!full || pop);
    assign drop          = push && full && !pop;

    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign level    = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_accepted) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_accepted) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // A drop and a clear in the same cycle leave the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_stream_source.sv
// Sample source for the FIR: pin samples captured on an asynchronous strobe or
// paced test patterns (ramp, impulse, step), buffered in a small FIFO.
module fir_stream_source
    import fir_stream_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int DEPTH    = 4,
    parameter int PACE_DIV = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_strobe,
    input  logic [1:0]               mode,
    input  logic                     clear_ovf,
    output logic [DATA_W-1:0]        m_axis_fir_tdata,
    output logic                     m_axis_fir_tvalid,
    input  logic                     m_axis_fir_tready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam logic [DATA_W-1:0] PEAK = DATA_W'(IMPULSE_VAL);

    mode_e              cur_mode;
    mode_e              mode_q;
    logic               mode_changed;

    logic [DATA_W:0]    sync_q1;
    logic [DATA_W:0]    sync_q2;
    logic               strobe_prev;
    logic               pin_push;
    logic [DATA_W-1:0]  pin_data;

    logic [PACE_W-1:0]  pace;
    logic               pace_hit;
    logic [DATA_W-1:0]  ramp_val;
    logic               impulse_done;
    logic               gen_push;
    logic [DATA_W-1:0]  gen_data;

    logic               push;
    logic [DATA_W-1:0]  push_data;
    logic               push_accepted;

    assign cur_mode     = mode_e'(mode);
    assign mode_changed = (cur_mode != mode_q);

    // Strobe and data share one synchroniser so the captured sample matches its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            strobe_prev <= 1'b0;
            pin_push    <= 1'b0;
            pin_data    <= '0;
        end else begin
            sync_q1     <= {in_strobe, in_data};
            sync_q2     <= sync_q1;
            strobe_prev <= sync_q2[DATA_W];
            pin_push    <= sync_q2[DATA_W] && !strobe_prev && (cur_mode == MODE_PIN);
            pin_data    <= sync_q2[DATA_W-1:0];
        end
    end

    assign pace_hit = (pace == PACE_W'(PACE_DIV - 1));
    assign gen_push = (cur_mode != MODE_PIN) && !mode_changed && pace_hit;

    always_comb begin
        gen_data = '0;
        case (cur_mode)
            MODE_RAMP:    gen_data = ramp_val;
            MODE_IMPULSE: gen_data = impulse_done ? '0 : PEAK;
            MODE_STEP:    gen_data = PEAK;
            default:      gen_data = '0;
        endcase
    end

    // Generator state only advances on accepted pushes, so a dropped sample is retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_PIN;
            pace         <= '0;
            ramp_val     <= '0;
            impulse_done <= 1'b0;
        end else begin
            mode_q <= cur_mode;
            if (mode_changed) begin
                pace         <= '0;
                ramp_val     <= '0;
                impulse_done <= 1'b0;
            end else if (cur_mode != MODE_PIN) begin
                pace <= pace_hit ? '0 : pace + 1'b1;
                if (gen_push && push_accepted) begin
                    if (cur_mode == MODE_RAMP) begin
                        ramp_val <= ramp_val + 1'b1;
                    end
                    if (cur_mode == MODE_IMPULSE) begin
                        impulse_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign push      = (cur_mode == MODE_PIN) ? pin_push : gen_push;
    assign push_data = (cur_mode == MODE_PIN) ? pin_data : gen_data;

    fir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_data     (push_data),
        .rd_ready      (m_axis_fir_tready),
        .clear_ovf     (clear_ovf),
        .rd_data       (m_axis_fir_tdata),
        .rd_valid      (m_axis_fir_tvalid),
        .level         (fifo_level),
        .push_accepted (push_accepted),
        .overflow      (overflow)
    );

endmodule

// File: tb/tb_fir_stream_source.sv
// Scoreboard bench for fir_stream_source: expected samples are queued as stimulus
// is issued and a negedge monitor checks every handshake beat and the hold rule.
module tb_fir_stream_source;

    localparam int DATA_W   = 6;
    localparam int DEPTH    = 4;
    localparam int PACE_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  in_data = '0;
    logic        in_strobe = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        clear_ovf = 1'b0;
    logic [5:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [2:0]  fifo_level;
    logic        overflow;

    int          n_checks = 0;
    int          n_fails = 0;
    int          cycle = 0;
    logic [5:0]  exp_q[$];
    int          beat_cyc[$];
    bit          prev_stall = 1'b0;
    logic [5:0]  prev_data = '0;

    fir_stream_source #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .PACE_DIV (PACE_DIV)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_data           (in_data),
        .in_strobe         (in_strobe),
        .mode              (mode),
        .clear_ovf         (clear_ovf),
        .m_axis_fir_tdata  (tdata),
        .m_axis_fir_tvalid (tvalid),
        .m_axis_fir_tready (tready),
        .fifo_level        (fifo_level),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every handshake pops one expected sample; stalls must hold data and valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cycle++;
            if (prev_stall) begin
                checkOutput("hold_tvalid", tvalid, 1);
                checkOutput("hold_tdata", tdata, prev_data);
            end
            if (tvalid === 1'b1 && tready === 1'b1) begin
                beat_cyc.push_back(cycle);
                if (exp_q.size() == 0) checkOutput("unexpected_beat", tdata, 999);
                else checkOutput("beat", tdata, exp_q.pop_front());
            end
            prev_stall = (tvalid === 1'b1) && (tready === 1'b0);
            prev_data  = tdata;
        end
    end

    // One pin sample: data set up 3 clocks before the strobe and held well after it.
    task automatic applyStimulus(input logic [5:0] d, input bit expect_push);
        @(posedge clk); #1;
        in_data = d;
        if (expect_push) exp_q.push_back(d);
        repeat (3) @(posedge clk);
        #1 in_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic waitEmpty(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() != 0 && n < budget);
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tvalid !== 1'b0 && n < budget);
        checkOutput("idle_tvalid", tvalid, 0);
    endtask

    task automatic pulseClear();
        clear_ovf = 1'b1;
        @(posedge clk); #1;
        clear_ovf = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int got;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset_tvalid", tvalid, 0);
        checkOutput("reset_tdata", tdata, 0);
        checkOutput("reset_level", fifo_level, 0);
        checkOutput("reset_overflow", overflow, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Asynchronous reset while a beat is waiting
        $display("[TB] async reset mid-transfer");
        tready = 1'b0;
        applyStimulus(6'h2A, 1'b0);
        @(negedge clk);
        checkOutput("pre_reset_tvalid", tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tvalid", tvalid, 0);
        checkOutput("async_reset_level", fifo_level, 0);
        checkOutput("async_reset_tdata", tdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single pin sample and its latency
        $display("[TB] pin path single sample");
        tready = 1'b1;
        in_data = 6'h15;
        exp_q.push_back(6'h15);
        repeat (3) @(posedge clk);
        #1 in_strobe = 1'b1;
        lat = 0;
        while (tvalid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("pin_latency", lat, 4);
        repeat (3) @(posedge clk);
        #1 in_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pin_level_after", fifo_level, 0);
        checkOutput("pin_tvalid_after", tvalid, 0);
        checkOutput("pin_pending", exp_q.size(), 0);

        // Overflow with tready low, then clear and set-wins
        $display("[TB] overflow under backpressure");
        tready = 1'b0;
        for (int k = 1; k <= 5; k++) applyStimulus(6'(k), k <= DEPTH);
        checkOutput("ovf_level", fifo_level, DEPTH);
        checkOutput("ovf_flag", overflow, 1);
        pulseClear();
        @(negedge clk);
        checkOutput("ovf_cleared", overflow, 0);
        @(posedge clk); #1 in_data = 6'h3F;
        repeat (3) @(posedge clk);
        #1 in_strobe = 1'b1;
        clear_ovf = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("ovf_set_wins", overflow, 1);
        @(posedge clk); #1;
        clear_ovf = 1'b0;
        checkOutput("ovf_clear_held", overflow, 0);
        repeat (3) @(posedge clk);
        #1 in_strobe = 1'b0;
        tready = 1'b1;
        waitEmpty(50);
        waitIdle(20);
        checkOutput("ovf_drained_level", fifo_level, 0);

        // Ramp with wrap and pacing
        $display("[TB] ramp");
        for (int k = 0; k < 70; k++) exp_q.push_back(6'(k % 64));
        beat_cyc.delete();
        mode = 2'd1;
        waitEmpty(400);
        mode = 2'd0;
        waitIdle(20);
        if (beat_cyc.size() >= 5) begin
            for (int i = 1; i < 5; i++) checkOutput("ramp_spacing", beat_cyc[i] - beat_cyc[i-1], PACE_DIV);
        end else begin
            checkOutput("ramp_beats", beat_cyc.size(), 70);
        end

        // Impulse then step
        $display("[TB] impulse and step");
        exp_q.push_back(6'd31);
        for (int k = 0; k < 4; k++) exp_q.push_back(6'd0);
        mode = 2'd2;
        waitEmpty(100);
        for (int k = 0; k < 4; k++) exp_q.push_back(6'd31);
        mode = 2'd3;
        waitEmpty(100);
        mode = 2'd0;
        waitIdle(20);

        // Full FIFO with simultaneous push and pop
        $display("[TB] full with push and pop together");
        tready = 1'b0;
        for (int k = 0; k < 10; k++) exp_q.push_back(6'(k));
        mode = 2'd1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fifo_level != DEPTH && n < 200);
        checkOutput("full_reached", fifo_level, DEPTH);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("full_before", fifo_level, DEPTH);
        tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("full_pushpop_level", fifo_level, DEPTH);
        checkOutput("full_pushpop_ovf", overflow, 0);
        waitEmpty(200);
        mode = 2'd0;
        waitIdle(20);

        // Random backpressure on a ramp
        $display("[TB] random tready");
        for (int k = 0; k < 100; k++) exp_q.push_back(6'(k % 64));
        @(posedge clk); #1 mode = 2'd1;
        repeat (300) begin
            @(posedge clk); #1;
            tready = 1'($urandom_range(0, 1));
        end
        mode = 2'd0;
        tready = 1'b1;
        waitIdle(20);
        got = 100 - exp_q.size();
        checkOutput("random_progress", got > 20, 1);
        exp_q.delete();
        pulseClear();
        @(negedge clk);
        checkOutput("final_overflow", overflow, 0);
        checkOutput("final_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
